// File: rtl/combo_lock_ctrl.sv
// rtl/combo_lock_ctrl.sv - parametrised combination lock with lockout, open window and code change
// Optional COMBO_LOCK_MASTER_OVERRIDE_EN: a MASTER_CODE entered during ALARM ends the lockout early.
module combo_lock_ctrl #(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] RESET_CODE = '0,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int OPEN_CYCLES    = 50
`ifdef COMBO_LOCK_MASTER_OVERRIDE_EN
  , parameter logic [DIGIT_W*CODE_LEN-1:0] MASTER_CODE = '1
`endif
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               digit_valid,
  input  logic [DIGIT_W-1:0]                 digit,
  input  logic                               enter,
  input  logic                               change,
  output logic                               open,
  output logic                               alarm,
  output logic                               prog,
  output logic                               code_updated,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

  localparam int CODE_W  = DIGIT_W * CODE_LEN;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_PROG, S_ALARM} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                open_q, alarm_q, prog_q, upd_q, upd_d;
  logic                len_ok, match, take_digit, clr;

  assign len_ok   = (cnt_q == CNT_W'(CODE_LEN)) && !ovf_q;
  assign match    = len_ok && (buf_q == code_q);
  assign fail_inc = (fail_q == FAIL_W'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    fail_d     = fail_q;
    tmr_d      = '0;
    upd_d      = 1'b0;
    take_digit = 1'b0;
    clr        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enter || change) begin
          clr = 1'b1;
          if (match) begin
            fail_d  = '0;
            state_d = enter ? S_OPEN : S_PROG;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FAIL_W'(MAX_FAILS)) state_d = S_ALARM;
          end
        end else if (digit_valid) begin
          take_digit = 1'b1;
        end
      end
      S_OPEN: begin
        if (tmr_q == TMR_W'(OPEN_CYCLES - 1)) state_d = S_IDLE;
        else                                   tmr_d   = tmr_q + 1'b1;
      end
      S_PROG: begin
        if (enter) begin
          clr     = 1'b1;
          state_d = S_IDLE;
          if (len_ok) begin
            code_d = buf_q;
            upd_d  = 1'b1;
          end
        end else if (change) begin
          clr     = 1'b1;
          state_d = S_IDLE;
        end else if (digit_valid) begin
          take_digit = 1'b1;
        end
      end
      default: begin
        if (tmr_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          fail_d  = '0;
          clr     = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
`ifdef COMBO_LOCK_MASTER_OVERRIDE_EN
          if (enter) begin
            clr = 1'b1;
            if (len_ok && (buf_q == MASTER_CODE)) begin
              state_d = S_IDLE;
              fail_d  = '0;
            end
          end else if (!change && digit_valid) begin
            take_digit = 1'b1;
          end
`endif
        end
      end
    endcase

    // Digit 0 lands in the MSBs; digits past CODE_LEN only mark overflow.
    if (take_digit) begin
      if (cnt_q == CNT_W'(CODE_LEN)) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < CODE_LEN; i++) begin
          if (cnt_q == CNT_W'(i)) buf_d[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (clr) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= RESET_CODE;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fail_q  <= '0;
      tmr_q   <= '0;
      open_q  <= 1'b0;
      alarm_q <= 1'b0;
      prog_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      open_q  <= (state_d == S_OPEN);
      alarm_q <= (state_d == S_ALARM);
      prog_q  <= (state_d == S_PROG);
      upd_q   <= upd_d;
    end
  end

  assign open         = open_q;
  assign alarm        = alarm_q;
  assign prog         = prog_q;
  assign code_updated = upd_q;
  assign fail_count   = fail_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb/tb_combo_lock_ctrl.sv - directed self-checking bench for combo_lock_ctrl
module tb_combo_lock_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'h0;
  logic       enter = 1'b0;
  logic       change = 1'b0;
  logic       open, alarm, prog, code_updated;
  logic [1:0] fail_count;

  int checks = 0;
  int errors = 0;

  combo_lock_ctrl #(
    .DIGIT_W(4), .CODE_LEN(4), .RESET_CODE(16'h1234), .MAX_FAILS(3),
    .LOCKOUT_CYCLES(20), .OPEN_CYCLES(8)
`ifdef COMBO_LOCK_MASTER_OVERRIDE_EN
    , .MASTER_CODE(16'hFFFF)
`endif
  ) dut (
    .clock(clock), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .change(change), .open(open), .alarm(alarm), .prog(prog),
    .code_updated(code_updated), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic code4(input logic [15:0] c);
    key(c[15:12]); key(c[11:8]); key(c[7:4]); key(c[3:0]);
  endtask

  task automatic press_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic press_change();
    change = 1'b1;
    tick();
    change = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_open", 32'(open), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_prog", 32'(prog), 32'd0);
    check("rst_upd", 32'(code_updated), 32'd0);
    check("rst_fail", 32'(fail_count), 32'd0);

    // Correct code opens for exactly 8 cycles
    code4(16'h1234);
    check("pre_open", 32'(open), 32'd0);
    press_enter();
    check("open_c1", 32'(open), 32'd1);
    check("open_fail", 32'(fail_count), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("open_hold", 32'(open), 32'd1);
    end
    tick();
    check("open_end", 32'(open), 32'd0);

    // Three wrong attempts -> lockout of 20 cycles
    code4(16'h1235); press_enter();
    check("fail1", 32'(fail_count), 32'd1);
    check("fail1_alarm", 32'(alarm), 32'd0);
    code4(16'h1235); press_enter();
    check("fail2", 32'(fail_count), 32'd2);
    code4(16'h1235); press_enter();
    check("alarm_c1", 32'(alarm), 32'd1);
    code4(16'h1234); press_enter();
    check("alarm_ignore_open", 32'(open), 32'd0);
    check("alarm_c6", 32'(alarm), 32'd1);
    for (int i = 7; i <= 20; i++) begin
      tick();
      check("alarm_hold", 32'(alarm), 32'd1);
    end
    tick();
    check("alarm_end", 32'(alarm), 32'd0);
    check("alarm_end_fail", 32'(fail_count), 32'd0);

    // Code change to 9876
    code4(16'h1234); press_change();
    check("prog_on", 32'(prog), 32'd1);
    check("prog_fail", 32'(fail_count), 32'd0);
    code4(16'h9876);
    check("prog_hold", 32'(prog), 32'd1);
    press_enter();
    check("upd_pulse", 32'(code_updated), 32'd1);
    check("prog_off", 32'(prog), 32'd0);
    tick();
    check("upd_drop", 32'(code_updated), 32'd0);
    code4(16'h1234); press_enter();
    check("old_code_fail", 32'(fail_count), 32'd1);
    check("old_code_open", 32'(open), 32'd0);
    code4(16'h9876); press_enter();
    check("new_code_open", 32'(open), 32'd1);
    check("new_code_fail", 32'(fail_count), 32'd0);
    repeat (8) tick();
    check("new_open_end", 32'(open), 32'd0);

    // Reset restores the original code
    do_reset();
    code4(16'h1234); press_enter();
    check("rst_code_open", 32'(open), 32'd1);
    repeat (8) tick();

    // Length errors
    key(4'h1); key(4'h2); key(4'h3); press_enter();
    check("short_fail", 32'(fail_count), 32'd1);
    check("short_open", 32'(open), 32'd0);
    code4(16'h1234); key(4'h5); press_enter();
    check("ovf_fail", 32'(fail_count), 32'd2);
    check("ovf_open", 32'(open), 32'd0);
    do_reset();
    key(4'h1); key(4'h2); key(4'h3);
    digit_valid = 1'b1; digit = 4'h4; enter = 1'b1;
    tick();
    digit_valid = 1'b0; enter = 1'b0;
    check("same_cycle_fail", 32'(fail_count), 32'd1);
    check("same_cycle_open", 32'(open), 32'd0);
    code4(16'h1234); press_enter();
    check("after_clr_open", 32'(open), 32'd1);
    check("after_clr_fail", 32'(fail_count), 32'd0);

    // Reset mid-OPEN (cycle 3)
    tick(); tick();
    check("mid_open_c3", 32'(open), 32'd1);
    do_reset();
    check("mid_open_rst", 32'(open), 32'd0);
    check("mid_open_rst_alarm", 32'(alarm), 32'd0);

    // PROG abort and PROG with bad length
    code4(16'h1234); press_change();
    check("abort_prog_on", 32'(prog), 32'd1);
    key(4'h5); key(4'h5); press_change();
    check("abort_prog_off", 32'(prog), 32'd0);
    check("abort_upd", 32'(code_updated), 32'd0);
    code4(16'h1234); press_enter();
    check("abort_code_kept", 32'(open), 32'd1);
    repeat (8) tick();
    code4(16'h1234); press_change();
    key(4'h5); key(4'h5); press_enter();
    check("badlen_prog_off", 32'(prog), 32'd0);
    check("badlen_upd", 32'(code_updated), 32'd0);
    check("badlen_fail", 32'(fail_count), 32'd0);
    code4(16'h1234); press_enter();
    check("badlen_code_kept", 32'(open), 32'd1);
    repeat (8) tick();

`ifdef COMBO_LOCK_MASTER_OVERRIDE_EN
    // Master code ends lockout early
    repeat (3) begin
      code4(16'h1111); press_enter();
    end
    check("m_alarm", 32'(alarm), 32'd1);
    code4(16'hFFFF);
    check("m_alarm_pre", 32'(alarm), 32'd1);
    press_enter();
    check("m_alarm_off", 32'(alarm), 32'd0);
    check("m_fail", 32'(fail_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
